// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe
//   Multi-lane vector ALU for the execute stage. Each accepted operation is
//   computed combinationally, captured into stage 1, and then moved through
//   a STAGES-deep valid/ready pipeline. The destination tag travels with each
//   result. The zero flag is used by the jump unit.
//
// Optional feature macro: SATURATE_EN
//   defined   : ADD/SUB saturate per lane in signed two's-complement and
//               out_sat reports the clamped lanes
//   undefined : all arithmetic wraps and out_sat is always 0
//
// Ports
//   clk, rst        : single clock; synchronous active-high reset
//   in_valid/ready  : input handshake; in_ready is combinational
//   in_a, in_b      : operands, lane i at [i*LANE_W +: LANE_W]
//   in_op           : 00 ADD, 01 SUB (A-B), 10 MUL (low half), 11 PASS B
//   in_vec          : 1 = all lanes, 0 = lane 0 only (upper lanes read as 0)
//   in_tag          : tag copied to out_tag
//   flush           : drops every in-flight op and the op offered this cycle
//   out_valid/ready : output handshake; outputs hold while stalled
//   out_result      : lane results
//   out_zero        : 1 when every lane of out_result is zero
//   out_tag         : tag of the presented result
//   out_sat         : per-lane saturation flags
module vector_alu_pipe #(
  parameter int LANES  = 6,
  parameter int LANE_W = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_a,
  input  logic [LANES*LANE_W-1:0] in_b,
  input  logic [1:0]              in_op,
  input  logic                    in_vec,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_result,
  output logic                    out_zero,
  output logic [TAG_W-1:0]        out_tag,
  output logic [LANES-1:0]        out_sat
);

  localparam int DW = LANES * LANE_W;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

`ifdef SATURATE_EN
  localparam int               MSB     = LANE_W - 1;
  localparam logic [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};
`endif

  logic [DW-1:0]     w_result;
  logic [LANES-1:0]  w_sat;
  logic              w_zero;
  logic [STAGES-1:0] w_ready;
  logic              w_accept;

  logic [STAGES-1:0] r_valid;
  logic [DW-1:0]     r_result [STAGES];
  logic              r_zero   [STAGES];
  logic [TAG_W-1:0]  r_tag    [STAGES];
  logic [LANES-1:0]  r_sat    [STAGES];

  // Per-lane arithmetic; lanes are independent, no carry crosses a lane.
  always_comb begin : lane_compute
    logic [LANE_W-1:0] v_a;
    logic [LANE_W-1:0] v_b;
    logic [LANE_W-1:0] v_sum;
    logic [LANE_W-1:0] v_diff;
    logic [LANE_W-1:0] v_lane;
    logic              v_sat;
    w_result = '0;
    w_sat    = '0;
    for (int i = 0; i < LANES; i++) begin
      v_a    = in_a[i*LANE_W +: LANE_W];
      v_b    = in_b[i*LANE_W +: LANE_W];
      v_sum  = v_a + v_b;
      v_diff = v_a - v_b;
      v_sat  = 1'b0;
      case (in_op)
        OP_ADD:  v_lane = v_sum;
        OP_SUB:  v_lane = v_diff;
        OP_MUL:  v_lane = v_a * v_b;
        OP_PASS: v_lane = v_b;
        default: v_lane = v_b;
      endcase
`ifdef SATURATE_EN
      // Signed overflow: operands of like sign (ADD) or unlike sign (SUB)
      // giving a result whose sign differs from A. Clamp toward A's sign.
      if ((in_op == OP_ADD) && (v_a[MSB] == v_b[MSB]) && (v_sum[MSB] != v_a[MSB])) begin
        v_sat  = 1'b1;
        v_lane = v_a[MSB] ? SAT_MIN : SAT_MAX;
      end else if ((in_op == OP_SUB) && (v_a[MSB] != v_b[MSB]) && (v_diff[MSB] != v_a[MSB])) begin
        v_sat  = 1'b1;
        v_lane = v_a[MSB] ? SAT_MIN : SAT_MAX;
      end else begin
        v_sat  = 1'b0;
      end
`endif
      // Scalar ops only produce lane 0; the rest read as zero.
      if (in_vec || (i == 0)) begin
        w_result[i*LANE_W +: LANE_W] = v_lane;
        w_sat[i]                     = v_sat;
      end else begin
        w_result[i*LANE_W +: LANE_W] = '0;
        w_sat[i]                     = 1'b0;
      end
    end
    // Upper lanes are already zero for scalar ops, so one test covers both modes.
    w_zero = (w_result == '0);
  end

  // Ready chain: a stage can load if it or any later stage has a hole, or
  // the consumer is taking the output this cycle.
  always_comb begin : ready_chain
    logic v_rdy;
    v_rdy   = out_ready;
    w_ready = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      v_rdy      = v_rdy | ~r_valid[k];
      w_ready[k] = v_rdy;
    end
  end

  assign in_ready = w_ready[0];
  // An op offered during flush is dropped even if in_ready is high.
  assign w_accept = in_valid & w_ready[0] & ~flush;

  // Pipeline registers: reset/flush clear valids, otherwise each ready stage
  // takes the contents of the stage before it (stage 1 takes the ALU output).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_result[k] <= '0;
        r_zero[k]   <= 1'b0;
        r_tag[k]    <= '0;
        r_sat[k]    <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      if (w_ready[0]) begin
        r_valid[0] <= w_accept;
        if (w_accept) begin
          r_result[0] <= w_result;
          r_zero[0]   <= w_zero;
          r_tag[0]    <= in_tag;
          r_sat[0]    <= w_sat;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_result[k] <= r_result[k-1];
            r_zero[k]   <= r_zero[k-1];
            r_tag[k]    <= r_tag[k-1];
            r_sat[k]    <= r_sat[k-1];
          end
        end
      end
    end
  end

  assign out_valid  = r_valid[STAGES-1];
  assign out_result = r_result[STAGES-1];
  assign out_zero   = r_zero[STAGES-1];
  assign out_tag    = r_tag[STAGES-1];
  assign out_sat    = r_sat[STAGES-1];

endmodule

// File: tb/tb_vector_alu_pipe.sv
module tb_vector_alu_pipe;

  localparam int LANES  = 6;
  localparam int LANE_W = 32;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  localparam int DW     = LANES * LANE_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in_a = '0;
  logic [DW-1:0]    in_b = '0;
  logic [1:0]       in_op = 2'b00;
  logic             in_vec = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_result;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;
  logic [LANES-1:0] out_sat;

  logic man_ready = 1'b1;
  logic rnd_mode  = 1'b0;
  logic rnd_ready = 1'b1;
  assign out_ready = rnd_mode ? rnd_ready : man_ready;

  typedef struct {
    logic [DW-1:0]    res;
    logic             zero;
    logic [TAG_W-1:0] tag;
    logic [LANES-1:0] sat;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_out   = 0;
  int   n_exp   = 0;

  vector_alu_pipe #(
    .LANES (LANES),
    .LANE_W(LANE_W),
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_vec    (in_vec),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_tag   (out_tag),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic per lane.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [1:0] op, input logic vec,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    longint unsigned x, y, t;
`ifdef SATURATE_EN
    longint sx, sy, s;
`endif
    e.res = '0;
    e.sat = '0;
    e.tag = tag;
    for (int i = 0; i < LANES; i++) begin
      if (vec || (i == 0)) begin
        x = longint'(a[i*LANE_W +: LANE_W]);
        y = longint'(b[i*LANE_W +: LANE_W]);
        case (op)
          2'd0:    t = x + y;
          2'd1:    t = x - y;
          2'd2:    t = x * y;
          default: t = y;
        endcase
`ifdef SATURATE_EN
        if (op == 2'd0 || op == 2'd1) begin
          sx = longint'(signed'(a[i*LANE_W +: LANE_W]));
          sy = longint'(signed'(b[i*LANE_W +: LANE_W]));
          s  = (op == 2'd0) ? sx + sy : sx - sy;
          if (s > 64'sd2147483647) begin
            t = 64'h7FFFFFFF;
            e.sat[i] = 1'b1;
          end else if (s < -64'sd2147483648) begin
            t = 64'h80000000;
            e.sat[i] = 1'b1;
          end else begin
            t = s;
          end
        end
`endif
        e.res[i*LANE_W +: LANE_W] = t[31:0];
      end
    end
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_exp -= sb.size();
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        chk("sb_nonempty", DW'(sb.size() > 0), DW'(1'b1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("res",  out_result,     e.res);
          chk("zero", DW'(out_zero),  DW'(e.zero));
          chk("tag",  DW'(out_tag),   DW'(e.tag));
          chk("sat",  DW'(out_sat),   DW'(e.sat));
        end
      end
      if (flush) begin
        n_exp -= sb.size();
        sb.delete();
      end else if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_op, in_vec, in_tag));
        n_exp++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op,
                       input logic vec, input logic [TAG_W-1:0] tag);
    in_a = a; in_b = b; in_op = op; in_vec = vec; in_tag = tag; in_valid = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op,
                      input logic vec, input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 1'b0;
    drive(a, b, op, vec, tag);
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accept", DW'(ok), DW'(1'b1));
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
    chk("drain", DW'(sb.size()), DW'(0));
  endtask

  task automatic rand_vec(output logic [DW-1:0] v);
    for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = $urandom();
  endtask

  initial begin
    logic [DW-1:0]    a, b, hold_res;
    logic [TAG_W-1:0] hold_tag;
    logic [DW-1:0]    bp_a [4];
    logic [DW-1:0]    bp_b [4];
    int               lat, idx, guard;

    // Reset held two cycles
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid",  DW'(out_valid), DW'(1'b0));
    chk("rst_out_result", out_result,     DW'(0));
    chk("rst_out_zero",   DW'(out_zero),  DW'(1'b0));
    chk("rst_out_tag",    DW'(out_tag),   DW'(0));
    chk("rst_out_sat",    DW'(out_sat),   DW'(0));
    chk("rst_in_ready",   DW'(in_ready),  DW'(1'b1));

    // Vector ADD with latency measurement
    for (int i = 0; i < LANES; i++) begin
      a[i*LANE_W +: LANE_W] = 32'(i + 1);
      b[i*LANE_W +: LANE_W] = 32'(10 * (i + 1));
    end
    drive(a, b, 2'b00, 1'b1, 4'd5);
    lat = 0;
    do begin
      tick();
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    chk("latency", DW'(lat), DW'(STAGES));
    chk("vadd_lane5", DW'(out_result[5*LANE_W +: LANE_W]), DW'(32'd66));
    chk("vadd_tag", DW'(out_tag), DW'(4'd5));
    drain();

    // Scalar SUB giving zero, upper lanes nonzero
    for (int i = 0; i < LANES; i++) begin
      a[i*LANE_W +: LANE_W] = 32'(100 + i);
      b[i*LANE_W +: LANE_W] = 32'(3 + i);
    end
    a[LANE_W-1:0] = 32'd7;
    b[LANE_W-1:0] = 32'd7;
    send(a, b, 2'b01, 1'b0, 4'd9);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    chk("ssub_zero",   DW'(out_zero), DW'(1'b1));
    chk("ssub_result", out_result,    DW'(0));
    drain();

    // Saturation boundary on lane 0
    a = '0; b = '0;
    a[LANE_W-1:0] = 32'h7FFFFFFF;
    b[LANE_W-1:0] = 32'h00000001;
    send(a, b, 2'b00, 1'b0, 4'd3);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
`ifdef SATURATE_EN
    chk("sat_lane0", DW'(out_result[LANE_W-1:0]), DW'(32'h7FFFFFFF));
    chk("sat_flag",  DW'(out_sat),                DW'(6'b000001));
`else
    chk("sat_lane0", DW'(out_result[LANE_W-1:0]), DW'(32'h80000000));
    chk("sat_flag",  DW'(out_sat),                DW'(6'b000000));
`endif
    drain();

    // Backpressure: 4 ops offered with out_ready low
    for (int i = 0; i < 4; i++) begin
      rand_vec(bp_a[i]);
      rand_vec(bp_b[i]);
    end
    man_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(bp_a[idx], bp_b[idx], 2'(idx), 1'b1, 4'(idx + 1));
      @(negedge clk);
      if (in_ready) idx++;
      tick();
    end
    chk("bp_accepted", DW'(idx), DW'(STAGES));
    chk("bp_in_ready", DW'(in_ready), DW'(1'b0));
    hold_res = out_result;
    hold_tag = out_tag;
    tick();
    chk("hold_res", out_result, hold_res);
    chk("hold_tag", DW'(out_tag), DW'(hold_tag));
    man_ready = 1'b1;
    @(negedge clk);
    chk("full_drain_fill", DW'(in_ready), DW'(1'b1));
    guard = 0;
    while (idx < 4 && guard < 50) begin
      drive(bp_a[idx], bp_b[idx], 2'(idx), 1'b1, 4'(idx + 1));
      @(negedge clk);
      if (in_ready) idx++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", DW'(idx), DW'(4));
    drain();

    // Flush with two ops in flight and a concurrent offer
    man_ready = 1'b0;
    rand_vec(a); rand_vec(b);
    send(a, b, 2'b10, 1'b1, 4'd11);
    send(b, a, 2'b00, 1'b1, 4'd12);
    drive(a, a, 2'b11, 1'b1, 4'd15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    man_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk("flush_valid", DW'(out_valid), DW'(1'b0));
      tick();
    end

    // Reset mid-operation
    man_ready = 1'b0;
    send(a, b, 2'b01, 1'b1, 4'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    man_ready = 1'b1;
    chk("rst2_out_valid",  DW'(out_valid), DW'(1'b0));
    chk("rst2_out_result", out_result,     DW'(0));
    chk("rst2_in_ready",   DW'(in_ready),  DW'(1'b1));

    // Random stream under random backpressure
    rnd_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rand_vec(a); rand_vec(b);
      send(a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    rnd_mode = 1'b0;
    drain();

    chk("out_count", DW'(n_out), DW'(n_exp));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
